seq_divider: RTL and testbench

- Sequential unsigned restoring divider: inverse of the 4-bit combinational multiplier; recovers quotient and remainder from an 8-bit product and a 4-bit factor.
- One quotient bit per clock behind a start/busy/done handshake.
- Used beside the multiplier for round-trip checks: a*b / b = a, remainder 0.

---
 rtl/seq_divider_pkg.sv | 29 ++
 rtl/seq_divider_if.sv | 46 ++++
 rtl/seq_divider_div_step.sv | 28 ++
 rtl/seq_divider.sv | 123 ++++++++++++
 tb/tb_seq_divider.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/seq_divider_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : div_pkg
//  Description : Shared types and constants for the sequential divider.
//  Revision    : 1.0
// ============================================================================
package div_pkg;

    localparam int DEF_DIVIDEND_W = 8;
    localparam int DEF_DIVISOR_W  = 4;

    // Counter width able to hold 0..n-1; never collapses to zero bits.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int CNT_W = cnt_width(DEF_DIVIDEND_W);

    // Quotient reported for a zero divisor at the default width.
    localparam logic [DEF_DIVIDEND_W-1:0] DIV0_QUOTIENT = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : div_pkg
`default_nettype wire

// File: rtl/seq_divider_if.sv
`default_nettype none
// ============================================================================
//  Module      : seq_divider_if
//  Description : Start/busy/done request and result bundle of the divider.
//  Revision    : 1.0
// ============================================================================
interface seq_divider_if
    import div_pkg::*;
#(
    parameter int DIVIDEND_W = DEF_DIVIDEND_W,
    parameter int DIVISOR_W  = DEF_DIVISOR_W
) ();

    logic                  start;
    logic [DIVIDEND_W-1:0] dividend;
    logic [DIVISOR_W-1:0]  divisor;
    logic                  busy;
    logic                  done;
    logic [DIVIDEND_W-1:0] quotient;
    logic [DIVISOR_W-1:0]  remainder;
    logic                  div_by_zero;

    modport master (
        output start,
        output dividend,
        output divisor,
        input  busy,
        input  done,
        input  quotient,
        input  remainder,
        input  div_by_zero
    );

    modport slave (
        input  start,
        input  dividend,
        input  divisor,
        output busy,
        output done,
        output quotient,
        output remainder,
        output div_by_zero
    );

endinterface : seq_divider_if
`default_nettype wire

// File: rtl/seq_divider_div_step.sv
`default_nettype none
// ============================================================================
//  Module      : div_step
//  Description : One restoring-division iteration (shift in, trial subtract).
//  Revision    : 1.0
// ============================================================================
module div_step #(
    parameter int DIVISOR_W = 4
) (
    input  wire logic [DIVISOR_W:0]   i_prem,
    input  wire logic                 i_bit,
    input  wire logic [DIVISOR_W-1:0] i_divisor,
    output logic      [DIVISOR_W:0]   o_prem,
    output logic                      o_qbit
);

    logic [DIVISOR_W+1:0] w_shifted;
    logic [DIVISOR_W:0]   w_trial;

    assign w_shifted = {i_prem, i_bit};

    // Compare on the full shifted width so the trial sign never aliases.
    assign o_qbit  = (w_shifted >= {2'b00, i_divisor});
    assign w_trial = w_shifted[DIVISOR_W:0] - {1'b0, i_divisor};
    assign o_prem  = o_qbit ? w_trial : w_shifted[DIVISOR_W:0];

endmodule : div_step
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
//  Module      : seq_divider
//  Description : Unsigned restoring divider, one quotient bit per clock.
//  Revision    : 1.0
// ============================================================================
module seq_divider
    import div_pkg::*;
#(
    parameter int DIVIDEND_W = DEF_DIVIDEND_W,
    parameter int DIVISOR_W  = DEF_DIVISOR_W
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    seq_divider_if.slave bus
);

    localparam int                 c_cnt_w = cnt_width(DIVIDEND_W);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(DIVIDEND_W - 1);

    state_t                r_state;
    state_t                w_state_next;
    logic                  w_accept;
    logic                  w_last;
    logic                  w_div0;

    logic [DIVISOR_W:0]    r_prem;
    logic [DIVISOR_W:0]    w_prem_next;
    logic                  w_qbit;
    logic [DIVIDEND_W-1:0] r_shift;
    logic [DIVISOR_W-1:0]  r_divisor;
    logic [c_cnt_w-1:0]    r_cnt;
    logic [DIVIDEND_W-1:0] r_quotient;
    logic [DIVISOR_W-1:0]  r_remainder;
    logic                  r_dbz;

    assign w_div0 = (bus.divisor == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_accept     = 1'b1;
                    w_state_next = w_div0 ? DONE : RUN;
                end
            end
            RUN: begin
                if (r_cnt == c_last) begin
                    w_last       = 1'b1;
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    div_step #(
        .DIVISOR_W (DIVISOR_W)
    ) u_step (
        .i_prem    (r_prem),
        .i_bit     (r_shift[DIVIDEND_W-1]),
        .i_divisor (r_divisor),
        .o_prem    (w_prem_next),
        .o_qbit    (w_qbit)
    );

    // The shift register doubles as the quotient accumulator: dividend bits
    // leave at the top while quotient bits enter at the bottom.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prem      <= '0;
            r_shift     <= '0;
            r_divisor   <= '0;
            r_cnt       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
        end else if (w_accept) begin
            r_dbz <= w_div0;
            if (w_div0) begin
                r_quotient  <= {DIVIDEND_W{1'b1}};
                r_remainder <= '0;
            end else begin
                r_divisor <= bus.divisor;
                r_prem    <= '0;
                r_shift   <= bus.dividend;
                r_cnt     <= '0;
            end
        end else if (r_state == RUN) begin
            r_prem  <= w_prem_next;
            r_shift <= {r_shift[DIVIDEND_W-2:0], w_qbit};
            r_cnt   <= r_cnt + c_cnt_w'(1);
            if (w_last) begin
                r_quotient  <= {r_shift[DIVIDEND_W-2:0], w_qbit};
                r_remainder <= w_prem_next[DIVISOR_W-1:0];
            end
        end
    end

    assign bus.busy        = (r_state == RUN);
    assign bus.done        = (r_state == DONE);
    assign bus.quotient    = r_quotient;
    assign bus.remainder   = r_remainder;
    assign bus.div_by_zero = r_dbz;

endmodule : seq_divider
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_divider
//  Description : Directed self-checking bench for seq_divider.
//  Revision    : 1.0
// ============================================================================
module tb_seq_divider;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    seq_divider_if #(.DIVIDEND_W(8), .DIVISOR_W(4)) bus ();

    seq_divider #(
        .DIVIDEND_W (8),
        .DIVISOR_W  (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: an accepted request finishes a fixed number of
    // edges later with plain arithmetic results.
    int         e         = 0;
    int         acc_edge  = -100;
    int         done_edge = -100;
    logic [7:0] mq        = 8'd0;
    logic [3:0] mr        = 4'd0;
    logic       mdbz      = 1'b0;

    always @(posedge clk or negedge rst_n) begin : model
        if (!rst_n) begin
            acc_edge  <= -100;
            done_edge <= -100;
            mq        <= 8'd0;
            mr        <= 4'd0;
            mdbz      <= 1'b0;
        end else begin
            e <= e + 1;
            if (bus.start && (e + 1 >= done_edge + 2)) begin
                acc_edge <= e + 1;
                if (bus.divisor == 4'd0) begin
                    done_edge <= e + 1;
                    mq        <= 8'hFF;
                    mr        <= 4'd0;
                    mdbz      <= 1'b1;
                end else begin
                    done_edge <= e + 9;
                    mq        <= 8'(int'(bus.dividend) / int'(bus.divisor));
                    mr        <= 4'(int'(bus.dividend) % int'(bus.divisor));
                    mdbz      <= 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        if (rst_n) begin
            chk("busy", bus.busy, (e >= acc_edge) && (e < done_edge));
            chk("done", bus.done, e == done_edge);
            if (e >= done_edge) begin
                chk("quotient", bus.quotient, mq);
                chk("remainder", bus.remainder, mr);
                chk("div_by_zero", bus.div_by_zero, mdbz);
            end
        end
    end

    task automatic reset_zero_check(input string tag);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_q"}, bus.quotient, 0);
        chk({tag, "_r"}, bus.remainder, 0);
        chk({tag, "_dbz"}, bus.div_by_zero, 0);
    endtask

    task automatic op(input logic [7:0] a, input logic [3:0] b,
                      input logic [7:0] eq, input logic [3:0] er, input logic edbz,
                      input int elat, input int inject_at, input int reset_at);
        int n;
        bit got;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        n   = 0;
        got = 0;
        while (!got && n < 30) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                bus.start    = 1'b0;
                bus.dividend = 8'($urandom);
                bus.divisor  = 4'($urandom);
                chk("model_q", mq, eq);
                chk("model_r", mr, er);
            end
            if (n == inject_at) begin
                bus.start    = 1'b1;
                bus.dividend = 8'd50;
                bus.divisor  = 4'd5;
            end
            if (inject_at != 0 && n == inject_at + 1) bus.start = 1'b0;
            if (n == reset_at) begin
                #3 rst_n = 1'b0;
                #1 reset_zero_check("abort");
                @(negedge clk);
                reset_zero_check("abort_hold");
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (bus.done) got = 1;
        end
        chk("done_negedges", n, elat);
        chk("op_q", bus.quotient, eq);
        chk("op_r", bus.remainder, er);
        chk("op_dbz", bus.div_by_zero, edbz);
    endtask

    initial begin : stim
        bus.start    = 1'b0;
        bus.dividend = 8'd0;
        bus.divisor  = 4'd0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_zero_check("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        op(8'd143, 4'd11, 8'd13,  4'd0, 1'b0, 9, 0, 0);
        op(8'd60,  4'd6,  8'd10,  4'd0, 1'b0, 9, 0, 0);
        op(8'd7,   4'd13, 8'd0,   4'd7, 1'b0, 9, 0, 0);
        op(8'd255, 4'd1,  8'd255, 4'd0, 1'b0, 9, 0, 0);
        op(8'd255, 4'd15, 8'd17,  4'd0, 1'b0, 9, 0, 0);
        op(8'd200, 4'd9,  8'd22,  4'd2, 1'b0, 9, 0, 0);
        op(8'd42,  4'd0,  8'hFF,  4'd0, 1'b1, 1, 0, 0);
        op(8'd100, 4'd7,  8'd14,  4'd2, 1'b0, 9, 3, 0);
        // Issued one cycle after the previous done: must be accepted.
        op(8'd91,  4'd7,  8'd13,  4'd0, 1'b0, 9, 0, 0);
        op(8'd143, 4'd11, 8'd13,  4'd0, 1'b0, 9, 0, 4);
        repeat (12) @(negedge clk);
        op(8'd143, 4'd11, 8'd13,  4'd0, 1'b0, 9, 0, 0);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule : tb_seq_divider
`default_nettype wire
